// File: rtl/alu_core.sv
// Registered 16-function ALU: operands are zero-extended to 2*WIDTH bits,
// and the result lands in c one clock after a, b and opcode are sampled.
module alu_core #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [3:0]         opcode,
   output logic [2*WIDTH-1:0] c
);

   localparam int W2 = 2 * WIDTH;

   logic [W2-1:0]    r_c;
   logic [W2-1:0]    w_a2;
   logic [W2-1:0]    w_b2;
   logic [W2-1:0]    w_dbl;
   logic [W2-1:0]    w_rol2;
   logic [W2-1:0]    w_ror2;
   logic [W2-1:0]    w_res;
   logic [WIDTH-1:0] w_rol;
   logic [WIDTH-1:0] w_ror;
   logic [2:0]       w_sh;
   logic             w_bz;

   assign w_a2 = {{WIDTH{1'b0}}, a};
   assign w_b2 = {{WIDTH{1'b0}}, b};
   assign w_sh = b[2:0];
   assign w_bz = (b == '0);

   // Rotating the doubled word moves the wrapped-around bits into the kept half.
   assign w_dbl  = {a, a};
   assign w_rol2 = w_dbl << w_sh;
   assign w_ror2 = w_dbl >> w_sh;
   assign w_rol  = w_rol2[W2-1:WIDTH];
   assign w_ror  = w_ror2[WIDTH-1:0];

   always_comb begin
      w_res = '0;
      case (opcode)
         4'h0: w_res = w_a2 + w_b2;
         4'h1: w_res = w_a2 - w_b2;
         4'h2: w_res = w_a2 * w_b2;
         4'h3: w_res = w_bz ? '1 : w_a2 / w_b2;
         4'h4: w_res = w_bz ? w_a2 : w_a2 % w_b2;
         4'h5: w_res = {{WIDTH{1'b0}}, a & b};
         4'h6: w_res = {{WIDTH{1'b0}}, a | b};
         4'h7: w_res = {{WIDTH{1'b0}}, a ^ b};
         4'h8: w_res = {{WIDTH{1'b0}}, ~a};
         4'h9: w_res = {{WIDTH{1'b0}}, a << w_sh};
         4'hA: w_res = {{WIDTH{1'b0}}, a >> w_sh};
         4'hB: w_res = {{WIDTH{1'b0}}, w_rol};
         4'hC: w_res = {{WIDTH{1'b0}}, w_ror};
         4'hD: w_res = w_a2 + 1'b1;
         4'hE: w_res = w_a2 - 1'b1;
         4'hF: w_res = {{(W2-3){1'b0}}, (a > b), (a == b), (a < b)};
         default: w_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_c <= '0;
      end else begin
         r_c <= w_res;
      end
   end

   assign c = r_c;

endmodule

// File: tb/tb_alu_core.sv
// Randomised scoreboard bench for alu_core against an integer reference model.
module tb_alu_core;

   logic        clk;
   logic        reset;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [3:0]  opcode;
   logic [15:0] c;

   typedef struct {
      logic [15:0] exp;
      logic [3:0]  op;
      logic        rst;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   logic [15:0] prev_exp;
   bit          have_prev = 0;

   alu_core #(.WIDTH(8)) dut (
      .clk(clk),
      .reset(reset),
      .a(a),
      .b(b),
      .opcode(opcode),
      .c(c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] model(input logic [7:0] av,
                                         input logic [7:0] bv,
                                         input logic [3:0] op);
      int unsigned x = av;
      int unsigned y = bv;
      int unsigned s = bv % 8;
      int unsigned r;
      case (op)
         4'h0: r = x + y;
         4'h1: r = x - y;
         4'h2: r = x * y;
         4'h3: r = (y == 0) ? 32'hFFFF : x / y;
         4'h4: r = (y == 0) ? x : x % y;
         4'h5: r = x & y;
         4'h6: r = x | y;
         4'h7: r = x ^ y;
         4'h8: r = 255 - x;
         4'h9: r = (x << s) & 255;
         4'hA: r = x >> s;
         4'hB: r = ((x << s) | (x >> (8 - s))) & 255;
         4'hC: r = ((x >> s) | (x << (8 - s))) & 255;
         4'hD: r = x + 1;
         4'hE: r = x - 1;
         default: r = (x > y ? 4 : 0) + (x == y ? 2 : 0) + (x < y ? 1 : 0);
      endcase
      return r[15:0];
   endfunction

   task automatic chk(input string name, input logic [15:0] act,
                      input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One edge of stimulus; optionally wiggles inputs and reset mid-cycle first.
   task automatic step(input logic r, input logic [7:0] av,
                       input logic [7:0] bv, input logic [3:0] op,
                       input bit hold);
      exp_t e;
      @(negedge clk);
      if (hold && have_prev) begin
         reset  = 1'b1;
         a      = ~av;
         b      = ~bv;
         opcode = ~op;
         #1;
         chk("hold", c, prev_exp);
      end
      reset  = r;
      a      = av;
      b      = bv;
      opcode = op;
      e.exp  = r ? 16'h0000 : model(av, bv, op);
      e.op   = op;
      e.rst  = r;
      q.push_back(e);
      prev_exp  = e.exp;
      have_prev = 1;
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk($sformatf("c op=%h rst=%0b", e.op, e.rst), c, e.exp);
      end
   end

   typedef struct {
      logic [7:0] av;
      logic [7:0] bv;
      logic [3:0] op;
      logic [15:0] want;
   } vec_t;

   vec_t dir[$] = '{
      '{8'hFF, 8'h01, 4'h0, 16'h0100}, '{8'hFF, 8'h01, 4'h1, 16'h00FE},
      '{8'hFF, 8'h01, 4'hD, 16'h0100}, '{8'hFF, 8'h01, 4'hE, 16'h00FE},
      '{8'h03, 8'h05, 4'h1, 16'hFFFE}, '{8'h03, 8'h05, 4'hF, 16'h0001},
      '{8'h03, 8'h05, 4'h3, 16'h0000}, '{8'h03, 8'h05, 4'h4, 16'h0003},
      '{8'h96, 8'h00, 4'h3, 16'hFFFF}, '{8'h96, 8'h00, 4'h4, 16'h0096},
      '{8'h96, 8'h00, 4'h8, 16'h0069}, '{8'h96, 8'h00, 4'hF, 16'h0004},
      '{8'h81, 8'h09, 4'h9, 16'h0002}, '{8'h81, 8'h09, 4'hA, 16'h0040},
      '{8'h81, 8'h09, 4'hB, 16'h0003}, '{8'h81, 8'h09, 4'hC, 16'h00C0}
   };

   initial begin
      reset  = 1'b1;
      a      = 8'hFF;
      b      = 8'hFF;
      opcode = 4'h2;

      step(1'b1, 8'hFF, 8'hFF, 4'h2, 0);
      step(1'b1, 8'hFF, 8'hFF, 4'h2, 0);
      step(1'b0, 8'hFF, 8'hFF, 4'h2, 0);
      @(posedge clk);
      #2;
      chk("rel_mul", c, 16'hFE01);

      foreach (dir[i]) begin
         step(1'b0, dir[i].av, dir[i].bv, dir[i].op, (i % 3) == 1);
         @(posedge clk);
         #2;
         chk($sformatf("dir%0d", i), c, dir[i].want);
      end

      for (int i = 0; i < 400; i++) begin
         logic r;
         r = ($urandom_range(0, 99) < 6);
         step(r, 8'($urandom), 8'($urandom), 4'($urandom),
              ($urandom_range(0, 9) == 0));
      end

      for (int i = 0; i < 3; i++) @(posedge clk);
      #2;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d left expected 0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
